// File: rtl/rx_dq_pkg.sv
// Shared definitions for the read-path DQ capture block: lane-mode
// encodings and the beat-width helper used by the packer.
package rx_dq_pkg;

  typedef enum logic [1:0] {
    LANE_X1   = 2'd0,
    LANE_X4   = 2'd1,
    LANE_X8   = 2'd2,
    LANE_RSVD = 2'd3
  } lane_mode_e;

  // Number of DQ bits contributed by one beat. DDR doubles the SDR width
  // because both the rising and falling halves are kept. The reserved
  // encoding falls through to x8 behaviour.
  function automatic logic [4:0] bits_per_beat(input logic [1:0] lane_mode,
                                               input logic       ddr_mode);
    logic [4:0] sdrBits;
    case (lane_mode_e'(lane_mode))
      LANE_X1: sdrBits = 5'd1;
      LANE_X4: sdrBits = 5'd4;
      default: sdrBits = 5'd8;
    endcase
    return ddr_mode ? (sdrBits << 1) : sdrBits;
  endfunction

endpackage

// File: rtl/rx_pack_fifo.sv
// Synchronous word FIFO behind the DQ packer: occupancy count, full/empty
// and threshold flags, registered read port, plus single-cycle drop and
// underflow pulses that the top turns into sticky flags.
module rx_pack_fifo
  import rx_dq_pkg::*;
#(
  parameter int DATA_WIDTH = 33,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  drop_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr_q;
  logic [ADDR_WIDTH-1:0] rdPtr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  doutValid_q;
  logic                  isEmpty;
  logic                  isFull;
  logic                  doPop;
  logic                  doPush;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when paired with a pop. Flush swallows both requests.
  assign doPop       = pop_i && !isEmpty && !flush_i;
  assign doPush      = push_i && (!isFull || doPop) && !flush_i;
  assign drop_o      = push_i && isFull && !doPop && !flush_i;
  assign underflow_o = pop_i && isEmpty && !flush_i;

  // Occupancy only moves when exactly one of push/pop is honoured.
  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array has no reset; its contents are only visible through
  // the pointers, which are reset.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  // Pointers, count and the registered read port. Flush returns to the
  // reset state but deliberately keeps the last word on dout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
    end else if (flush_i) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      doutValid_q <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
        dout_q  <= mem_q[rdPtr_q];
      end
      doutValid_q <= doPop;
      count_q     <= count_d;
    end
  end

  assign dout_o         = dout_q;
  assign dout_valid_o   = doutValid_q;
  assign empty_o        = isEmpty;
  assign full_o         = isFull;
  assign almost_full_o  = (count_q >= AFULL_CNT);
  assign almost_empty_o = (count_q <= AEMPTY_CNT);
  assign count_o        = count_q;

endmodule

// File: rtl/rx_dq_pack_capture.sv
// Read-path DQ capture: packs PHY-sampled DQ beats MSB-first into
// OUT_WIDTH words, flushes partial words on the last beat of a burst, and
// queues {last, word} entries in the rx_pack_fifo for the read mover.
module rx_dq_pack_capture
  import rx_dq_pkg::*;
#(
  parameter int OUT_WIDTH       = 32,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int AFULL_LVL       = 12,
  parameter int AEMPTY_LVL      = 2
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               lane_mode,
  input  logic                     ddr_mode,
  input  logic                     dq_valid,
  input  logic [7:0]               dq_rise,
  input  logic [7:0]               dq_fall,
  input  logic                     dq_last,
  input  logic                     rd_en,
  output logic [OUT_WIDTH-1:0]     dout,
  output logic                     dout_last,
  output logic                     dout_valid,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [FIFO_ADDR_WIDTH:0] data_avail,
  output logic                     stall_req,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CNT_W = $clog2(OUT_WIDTH) + 1;
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(OUT_WIDTH);

  logic [OUT_WIDTH-1:0] sr_q;
  logic [OUT_WIDTH-1:0] sr_d;
  logic [CNT_W-1:0]     packCnt_q;
  logic [CNT_W-1:0]     packCnt_d;
  logic                 push_q;
  logic                 push_d;
  logic [OUT_WIDTH-1:0] pushWord_q;
  logic [OUT_WIDTH-1:0] pushWord_d;
  logic                 pushLast_q;
  logic                 pushLast_d;
  logic                 overflow_q;
  logic                 underflow_q;

  logic [15:0]          beatBits;
  logic [4:0]           beatWidth;
  logic [OUT_WIDTH-1:0] srShifted;
  logic [OUT_WIDTH-1:0] srJustified;
  logic [CNT_W-1:0]     cntSum;
  logic [OUT_WIDTH:0]   fifoDout;
  logic                 fifoDrop;
  logic                 fifoUnderflow;

  // Gather the active lanes of this beat into a right-aligned field,
  // rising half first so it lands in the more significant position.
  always_comb begin
    beatBits = '0;
    case (lane_mode_e'(lane_mode))
      LANE_X1: beatBits = ddr_mode ? {14'd0, dq_rise[1], dq_fall[1]}
                                   : {15'd0, dq_rise[1]};
      LANE_X4: beatBits = ddr_mode ? {8'd0, dq_rise[3:0], dq_fall[3:0]}
                                   : {12'd0, dq_rise[3:0]};
      default: beatBits = ddr_mode ? {dq_rise, dq_fall}
                                   : {8'd0, dq_rise};
    endcase
  end

  assign beatWidth   = bits_per_beat(lane_mode, ddr_mode);
  assign srShifted   = (sr_q << beatWidth) | OUT_WIDTH'(beatBits);
  assign cntSum      = packCnt_q + CNT_W'(beatWidth);
  assign srJustified = srShifted << (WORD_BITS - cntSum);

  // Packer next state: a beat either extends the partial word or closes
  // it (word full or burst end), staging the left-justified word for a
  // FIFO push on the following cycle. Flush drops everything in flight.
  always_comb begin
    sr_d       = sr_q;
    packCnt_d  = packCnt_q;
    push_d     = 1'b0;
    pushWord_d = pushWord_q;
    pushLast_d = 1'b0;
    if (flush) begin
      sr_d      = '0;
      packCnt_d = '0;
    end else if (dq_valid) begin
      if ((cntSum == WORD_BITS) || dq_last) begin
        push_d     = 1'b1;
        pushWord_d = srJustified;
        pushLast_d = dq_last;
        sr_d       = '0;
        packCnt_d  = '0;
      end else begin
        sr_d      = srShifted;
        packCnt_d = cntSum;
      end
    end
  end

  // Packer registers and the staged push toward the FIFO.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      packCnt_q  <= '0;
      push_q     <= 1'b0;
      pushWord_q <= '0;
      pushLast_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      packCnt_q  <= packCnt_d;
      push_q     <= push_d;
      pushWord_q <= pushWord_d;
      pushLast_q <= pushLast_d;
    end
  end

  // Sticky error flags collect single-cycle FIFO events until flush/reset.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | fifoDrop;
      underflow_q <= underflow_q | fifoUnderflow;
    end
  end

  rx_pack_fifo #(
    .DATA_WIDTH (OUT_WIDTH + 1),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) u_fifo (
    .clk_i          (mem_clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .push_i         (push_q),
    .push_data_i    ({pushLast_q, pushWord_q}),
    .pop_i          (rd_en),
    .dout_o         (fifoDout),
    .dout_valid_o   (dout_valid),
    .empty_o        (fifo_empty),
    .full_o         (fifo_full),
    .almost_full_o  (fifo_almost_full),
    .almost_empty_o (fifo_almost_empty),
    .count_o        (data_avail),
    .drop_o         (fifoDrop),
    .underflow_o    (fifoUnderflow)
  );

  assign dout      = fifoDout[OUT_WIDTH-1:0];
  assign dout_last = fifoDout[OUT_WIDTH];
  assign stall_req = fifo_almost_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rx_dq_pack_capture.sv
// Self-checking bench for rx_dq_pack_capture. The reference model treats
// the packer as a plain bit queue (lanes MSB first, rise before fall) and
// the FIFO as a bounded queue of {last, word} entries.
module tb_rx_dq_pack_capture;

  localparam int W      = 32;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic          mem_clk;
  logic          rst;
  logic          flush;
  logic [1:0]    lane_mode;
  logic          ddr_mode;
  logic          dq_valid;
  logic [7:0]    dq_rise;
  logic [7:0]    dq_fall;
  logic          dq_last;
  logic          rd_en;
  logic [W-1:0]  dout;
  logic          dout_last;
  logic          dout_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_almost_empty;
  logic [AW:0]   data_avail;
  logic          stall_req;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  bit           modelBits[$];
  logic [W:0]   modelFifo[$];
  bit           modelOvf;
  bit           modelUdf;

  rx_dq_pack_capture #(
    .OUT_WIDTH       (W),
    .FIFO_ADDR_WIDTH (AW),
    .AFULL_LVL       (AFULL),
    .AEMPTY_LVL      (AEMPTY)
  ) dut (
    .mem_clk           (mem_clk),
    .rst               (rst),
    .flush             (flush),
    .lane_mode         (lane_mode),
    .ddr_mode          (ddr_mode),
    .dq_valid          (dq_valid),
    .dq_rise           (dq_rise),
    .dq_fall           (dq_fall),
    .dq_last           (dq_last),
    .rd_en             (rd_en),
    .dout              (dout),
    .dout_last         (dout_last),
    .dout_valid        (dout_valid),
    .fifo_empty        (fifo_empty),
    .fifo_full         (fifo_full),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .data_avail        (data_avail),
    .stall_req         (stall_req),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  // Free-running 100 MHz memory clock.
  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Model state back to power-on: nothing packed, nothing queued, no flags.
  function automatic void modelClear();
    modelBits.delete();
    modelFifo.delete();
    modelOvf = 1'b0;
    modelUdf = 1'b0;
  endfunction

  // Append one beat's bits to the model and close a word when 32 bits have
  // been gathered or the burst ends.
  function automatic void modelBeat(input logic [1:0] lm, input logic ddr,
                                    input logic [7:0] r, input logic [7:0] f,
                                    input logic last);
    int         lanes;
    logic [7:0] half;
    logic [W-1:0] word;
    lanes = (lm == 2'd0) ? 1 : (lm == 2'd1) ? 4 : 8;
    for (int h = 0; h < (ddr ? 2 : 1); h++) begin
      half = (h == 0) ? r : f;
      if (lanes == 1) begin
        modelBits.push_back(half[1]);
      end else begin
        for (int i = lanes - 1; i >= 0; i--) modelBits.push_back(half[i]);
      end
    end
    if (modelBits.size() == W || last) begin
      word = '0;
      for (int i = 0; i < modelBits.size(); i++) word[W-1-i] = modelBits[i];
      if (modelFifo.size() < DEPTH) modelFifo.push_back({last, word});
      else modelOvf = 1'b1;
      modelBits.delete();
    end
  endfunction

  // Present one beat for exactly one clock; consecutive calls form a
  // gap-free burst.
  task automatic applyStimulus(input logic [1:0] lm, input logic ddr,
                               input logic [7:0] r, input logic [7:0] f,
                               input logic last);
    lane_mode = lm;
    ddr_mode  = ddr;
    dq_rise   = r;
    dq_fall   = f;
    dq_last   = last;
    dq_valid  = 1'b1;
    @(posedge mem_clk); #1;
    dq_valid  = 1'b0;
    dq_last   = 1'b0;
    modelBeat(lm, ddr, r, f, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge mem_clk); #1;
    end
  endtask

  // One-cycle rd_en pulse; returns what the read port shows afterwards.
  task automatic readWord(output logic [W-1:0] d, output logic l,
                          output logic v);
    rd_en = 1'b1;
    @(posedge mem_clk); #1;
    rd_en = 1'b0;
    d = dout;
    l = dout_last;
    v = dout_valid;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(posedge mem_clk); #1;
    flush = 1'b0;
    modelClear();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; lane_mode = 2'd0; ddr_mode = 1'b0;
    dq_valid = 1'b0; dq_rise = '0; dq_fall = '0; dq_last = 1'b0; rd_en = 1'b0;
    modelClear();
    #12;
    checks++;
    if (dout !== '0 || dout_last !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dout: got dout=%h last=%b valid=%b expected 0/0/0",
               dout, dout_last, dout_valid);
    end
    checks++;
    if (data_avail !== '0 || fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_level: got avail=%0d empty=%b aempty=%b expected 0/1/1",
               data_avail, fifo_empty, fifo_almost_empty);
    end
    checks++;
    if ({fifo_full, fifo_almost_full, stall_req, overflow, underflow} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got full/afull/stall/ovf/udf=%b expected 00000",
               {fifo_full, fifo_almost_full, stall_req, overflow, underflow});
    end
    @(posedge mem_clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_x8_ddr();
    logic [W-1:0] d; logic l; logic v; logic [W:0] e;
    applyStimulus(2'd2, 1'b1, 8'hA1, 8'hB2, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'hC3, 8'hD4, 1'b0);
    checks++;
    if (data_avail !== 0) begin
      errors++;
      $display("[TB] FAIL x8ddr_latency: got avail=%0d expected 0", data_avail);
    end
    idle(1);
    checks++;
    if (data_avail !== 1 || fifo_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x8ddr_push: got avail=%0d empty=%b expected 1/0",
               data_avail, fifo_empty);
    end
    e = modelFifo.pop_front();
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'hA1B2C3D4 || l !== 1'b0 || {l, d} !== e) begin
      errors++;
      $display("[TB] FAIL x8ddr_word: got valid=%b last=%b dout=%h expected 1/0/a1b2c3d4",
               v, l, d);
    end
    idle(1);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 32'hA1B2C3D4) begin
      errors++;
      $display("[TB] FAIL x8ddr_hold: got valid=%b dout=%h expected 0/a1b2c3d4",
               dout_valid, dout);
    end
  endtask

  task automatic test_narrow_sdr();
    logic [W-1:0] d; logic l; logic v;
    for (int i = 0; i < 32; i++)
      applyStimulus(2'd0, 1'b0, (i % 2 == 0) ? 8'h02 : 8'hFD, 8'hFF, 1'b0);
    idle(1);
    void'(modelFifo.pop_front());
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'hAAAAAAAA || l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x1sdr_word: got valid=%b last=%b dout=%h expected 1/0/aaaaaaaa",
               v, l, d);
    end
    for (int i = 0; i < 8; i++)
      applyStimulus(2'd1, 1'b0, 8'(i) | 8'hF0, 8'hFF, 1'b0);
    idle(1);
    void'(modelFifo.pop_front());
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h01234567 || l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x4sdr_word: got valid=%b last=%b dout=%h expected 1/0/01234567",
               v, l, d);
    end
  endtask

  task automatic test_last_partial();
    logic [W-1:0] d; logic l; logic v;
    applyStimulus(2'd2, 1'b0, 8'h11, 8'hEE, 1'b0);
    applyStimulus(2'd2, 1'b0, 8'h22, 8'hEE, 1'b0);
    applyStimulus(2'd2, 1'b0, 8'h33, 8'hEE, 1'b1);
    idle(1);
    void'(modelFifo.pop_front());
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h11223300 || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL last_partial: got valid=%b last=%b dout=%h expected 1/1/11223300",
               v, l, d);
    end
    applyStimulus(2'd2, 1'b1, 8'h9A, 8'hBC, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'hDE, 8'hF0, 1'b1);
    idle(1);
    checks++;
    if (data_avail !== 1) begin
      errors++;
      $display("[TB] FAIL last_exact_count: got avail=%0d expected 1", data_avail);
    end
    void'(modelFifo.pop_front());
    readWord(d, l, v);
    checks++;
    if (d !== 32'h9ABCDEF0 || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL last_exact_word: got last=%b dout=%h expected 1/9abcdef0", l, d);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] d; logic l; logic v; logic [W:0] e; int n;
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(2'd2, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      applyStimulus(2'd2, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      idle(2);
      n = modelFifo.size();
      checks++;
      if (data_avail !== (AW+1)'(n) || fifo_almost_full !== (n >= AFULL) ||
          stall_req !== (n >= AFULL) || fifo_full !== (n == DEPTH) ||
          fifo_almost_empty !== (n <= AEMPTY) || overflow !== modelOvf) begin
        errors++;
        $display("[TB] FAIL fill_%0d: got avail=%0d afull=%b stall=%b full=%b aempty=%b ovf=%b expected avail=%0d ovf=%b",
                 k, data_avail, fifo_almost_full, stall_req, fifo_full,
                 fifo_almost_empty, overflow, n, modelOvf);
      end
    end
    while (modelFifo.size() > 0) begin
      e = modelFifo.pop_front();
      readWord(d, l, v);
      checks++;
      if (v !== 1'b1 || {l, d} !== e) begin
        errors++;
        $display("[TB] FAIL drain_word: got valid=%b {last,dout}=%h expected 1/%h",
                 v, {l, d}, e);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_end: got empty=%b ovf=%b expected 1/1", fifo_empty, overflow);
    end
  endtask

  task automatic test_underflow();
    logic [W-1:0] d; logic l; logic v;
    doFlush();
    readWord(d, l, v);
    modelUdf = 1'b1;
    checks++;
    if (v !== 1'b0 || underflow !== modelUdf || fifo_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow: got valid=%b udf=%b empty=%b expected 0/1/1",
               v, underflow, fifo_empty);
    end
  endtask

  task automatic test_push_pop_empty();
    logic [W-1:0] d; logic l; logic v;
    doFlush();
    applyStimulus(2'd2, 1'b0, 8'h5A, 8'h00, 1'b1);
    readWord(d, l, v);
    modelUdf = 1'b1;
    checks++;
    if (v !== 1'b0 || data_avail !== 1 || underflow !== modelUdf) begin
      errors++;
      $display("[TB] FAIL pushpop_empty: got valid=%b avail=%0d udf=%b expected 0/1/1",
               v, data_avail, underflow);
    end
    void'(modelFifo.pop_front());
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h5A000000 || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pushpop_word: got valid=%b last=%b dout=%h expected 1/1/5a000000",
               v, l, d);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] d; logic l; logic v;
    applyStimulus(2'd2, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    doFlush();
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || data_avail !== 0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_clear: got ovf=%b udf=%b avail=%0d empty=%b expected 0/0/0/1",
               overflow, underflow, data_avail, fifo_empty);
    end
    applyStimulus(2'd2, 1'b1, 8'h55, 8'h66, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'h77, 8'h88, 1'b0);
    idle(1);
    checks++;
    if (data_avail !== 1) begin
      errors++;
      $display("[TB] FAIL flush_count: got avail=%0d expected 1", data_avail);
    end
    void'(modelFifo.pop_front());
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h55667788 || l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_word: got valid=%b last=%b dout=%h expected 1/0/55667788",
               v, l, d);
    end
    applyStimulus(2'd2, 1'b1, 8'h12, 8'h34, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'h56, 8'h78, 1'b0);
    doFlush();
    idle(1);
    checks++;
    if (data_avail !== 0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_pending_push: got avail=%0d empty=%b expected 0/1",
               data_avail, fifo_empty);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d; logic l; logic v; logic [W:0] e;
    logic [1:0] lm; logic ddr; int nBeats;
    for (int r = 0; r < 8; r++) begin
      doFlush();
      lm     = 2'($urandom_range(0, 3));
      ddr    = 1'($urandom_range(0, 1));
      nBeats = $urandom_range(1, 40);
      for (int i = 0; i < nBeats; i++)
        applyStimulus(lm, ddr, 8'($urandom), 8'($urandom), (i == nBeats - 1));
      idle(2);
      checks++;
      if (data_avail !== (AW+1)'(modelFifo.size()) || overflow !== modelOvf) begin
        errors++;
        $display("[TB] FAIL rand_%0d_level: mode=%0d ddr=%b beats=%0d got avail=%0d ovf=%b expected %0d/%b",
                 r, lm, ddr, nBeats, data_avail, overflow, modelFifo.size(), modelOvf);
      end
      while (modelFifo.size() > 0) begin
        e = modelFifo.pop_front();
        readWord(d, l, v);
        checks++;
        if (v !== 1'b1 || {l, d} !== e) begin
          errors++;
          $display("[TB] FAIL rand_%0d_word: mode=%0d ddr=%b got valid=%b {last,dout}=%h expected 1/%h",
                   r, lm, ddr, v, {l, d}, e);
        end
      end
    end
  endtask

  task automatic test_rst_mid_burst();
    logic [W-1:0] d; logic l; logic v; logic [W:0] e;
    doFlush();
    applyStimulus(2'd2, 1'b1, 8'hC0, 8'hFF, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'hEE, 8'h01, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'h13, 8'h57, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'h9B, 8'hDF, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'hAB, 8'hCD, 1'b0);
    readWord(d, l, v);
    #2;
    rst = 1'b1;
    #1;
    modelClear();
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || dout_last !== 1'b0 || data_avail !== 0 ||
        fifo_empty !== 1'b1 || fifo_almost_empty !== 1'b1 ||
        {fifo_full, fifo_almost_full, stall_req, overflow, underflow} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid: got dout=%h valid=%b avail=%0d empty=%b expected 0/0/0/1",
               dout, dout_valid, data_avail, fifo_empty);
    end
    @(posedge mem_clk); #1;
    rst = 1'b0;
    idle(1);
    applyStimulus(2'd2, 1'b1, 8'h24, 8'h68, 1'b0);
    applyStimulus(2'd2, 1'b1, 8'hAC, 8'hE0, 1'b0);
    idle(1);
    e = modelFifo.pop_front();
    readWord(d, l, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h2468ACE0 || {l, d} !== e) begin
      errors++;
      $display("[TB] FAIL rst_resume: got valid=%b dout=%h expected 1/2468ace0", v, d);
    end
  endtask

  // Scenario sequence; each task leaves the DUT idle for the next one.
  initial begin
    test_reset();
    test_x8_ddr();
    test_narrow_sdr();
    test_last_partial();
    test_overflow();
    test_underflow();
    test_push_pop_empty();
    test_flush();
    test_random();
    test_rst_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
